// File: rtl/cdb_writeback_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_writeback_arbiter_pkg
// Shared widths and types for the result write-back path. This package holds
// the data width, the physical register file geometry, the default number of
// CDB requesters, the {tag, data} result packet, and a helper that sizes index
// fields.
// -----------------------------------------------------------------------------
package cdb_writeback_arbiter_pkg;

  localparam int XLEN          = 32;
  localparam int NUM_PHYS_REGS = 64;
  localparam int PREG_W        = $clog2(NUM_PHYS_REGS);
  localparam int NUM_CDB_REQ   = 4;

  // One completed result: destination physical register and its value.
  typedef struct packed {
    logic [PREG_W-1:0] tag;
    logic [XLEN-1:0]   data;
  } cdb_pkt_t;

  // Width of an index that selects one of n items. The result is never zero,
  // so a single-entry index still has one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_writeback_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_writeback_arbiter_if
// Bundles the functional-unit request side and the PRF / CDB result side of
// the write-back arbiter.
//   flush                       squash all buffered and in-flight results
//   req_valid/req_ready         per-FU handshake
//   req_tag/req_data            per-FU result; slice i belongs to FU i
//   prf_write_*                 PRF data write port
//   prf_status_wr_*             PRF status-valid write port
//   cdb_valid/tag/data/src      broadcast to the reservation stations
//
// Handshake rule: FU i transfers one result on a rising edge where both
// req_valid[i] and req_ready[i] are high. Once an FU raises req_valid[i], it
// keeps the valid signal and its tag/data stable until that transfer happens.
// req_ready[i] does not depend on req_valid[i].
// -----------------------------------------------------------------------------
interface cdb_writeback_arbiter_if #(
  parameter int NUM_REQ = cdb_writeback_arbiter_pkg::NUM_CDB_REQ
);
  import cdb_writeback_arbiter_pkg::*;

  localparam int SRC_W = idx_width(NUM_REQ);

  logic                      flush;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*PREG_W-1:0] req_tag;
  logic [NUM_REQ*XLEN-1:0]   req_data;

  logic                      prf_write_en;
  logic [PREG_W-1:0]         prf_write_addr;
  logic [XLEN-1:0]           prf_write_data;
  logic                      prf_status_wr_en;
  logic [PREG_W-1:0]         prf_status_wr_addr;
  logic                      cdb_valid;
  logic [PREG_W-1:0]         cdb_tag;
  logic [XLEN-1:0]           cdb_data;
  logic [SRC_W-1:0]          cdb_src;

  // Execution-unit / environment side
  modport master (
    output flush, req_valid, req_tag, req_data,
    input  req_ready,
    input  prf_write_en, prf_write_addr, prf_write_data,
    input  prf_status_wr_en, prf_status_wr_addr,
    input  cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  // Arbiter side
  modport slave (
    input  flush, req_valid, req_tag, req_data,
    output req_ready,
    output prf_write_en, prf_write_addr, prf_write_data,
    output prf_status_wr_en, prf_status_wr_addr,
    output cdb_valid, cdb_tag, cdb_data, cdb_src
  );

endinterface

// File: rtl/cdb_writeback_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// This is a round-robin arbiter for N requesters. It produces at most one grant
// per cycle. The search starts at an internal pointer. After each grant, the
// pointer moves to the slot just past the winner, so the winner has the lowest
// priority on the next search.
//   clk, rst       clock, asynchronous active-high reset (pointer -> 0)
//   req_i          request vector
//   grant_o        one-hot grant (all zero when nothing requests)
//   grant_idx_o    index of the granted requester
//   any_grant_o    a grant was issued this cycle
// -----------------------------------------------------------------------------
module rr_arbiter
  import cdb_writeback_arbiter_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = idx_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             any_grant_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  // The search runs in two passes. The first pass covers the requesters at
  // or above the pointer. The second pass wraps around to the requesters
  // below the pointer. The first hit wins.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_grant_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any_grant_o && req_i[i] && (i >= int'(ptr_q))) begin
        grant_o[i]  = 1'b1;
        grant_idx_o = IDX_W'(i);
        any_grant_o = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any_grant_o && req_i[i] && (i < int'(ptr_q))) begin
        grant_o[i]  = 1'b1;
        grant_idx_o = IDX_W'(i);
        any_grant_o = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (any_grant_o) begin
      ptr_d = (grant_idx_o == IDX_W'(N - 1)) ? '0 : grant_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cdb_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_writeback_arbiter
// This block shares the single PRF result write port, its status-valid write,
// and the CDB broadcast among NUM_REQ functional units. Each FU hands its
// result into a one-entry holding buffer. A round-robin arbiter selects one
// buffered result per cycle. The selected result goes through a registered
// output stage.
//   clk, rst   clock, asynchronous active-high reset
//   bus        cdb_writeback_arbiter_if.slave (requests in, PRF/CDB out)
// -----------------------------------------------------------------------------
module cdb_writeback_arbiter
  import cdb_writeback_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_CDB_REQ
) (
  input logic                    clk,
  input logic                    rst,
  cdb_writeback_arbiter_if.slave bus
);

  localparam int SRC_W = idx_width(NUM_REQ);

  // Holding buffers
  logic [NUM_REQ-1:0] buf_v_q, buf_v_d;
  cdb_pkt_t           buf_q [NUM_REQ];
  cdb_pkt_t           buf_d [NUM_REQ];

  // Arbitration
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] grant;
  logic [SRC_W-1:0]   grant_idx;
  logic               any_grant;

  // Handshake
  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] accept;

  // Output stage
  logic               out_v_q, out_v_d;
  cdb_pkt_t           out_pkt_q, out_pkt_d;
  logic [SRC_W-1:0]   out_src_q, out_src_d;

  // Masking the arbiter input during flush prevents a grant in that cycle.
  // This keeps the pointer where it is and leaves the output stage invalid
  // on the next cycle.
  assign arb_req = buf_v_q & {NUM_REQ{~bus.flush}};

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .clk         (clk),
    .rst         (rst),
    .req_i       (arb_req),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_grant_o (any_grant)
  );

  // A buffer that is granted this cycle can take a new result on the same
  // edge. This lets each FU issue one result per cycle.
  assign ready         = {NUM_REQ{~rst & ~bus.flush}} & (~buf_v_q | grant);
  assign accept        = ready & bus.req_valid;
  assign bus.req_ready = ready;

  // Buffer next state. A refill takes priority over the clear that a grant
  // would otherwise cause. Flush clears every buffer; ready is low during
  // flush, so no refill can happen in that cycle.
  always_comb begin
    buf_v_d = buf_v_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      buf_d[i] = buf_q[i];
      if (accept[i]) begin
        buf_v_d[i]    = 1'b1;
        buf_d[i].tag  = bus.req_tag[i*PREG_W +: PREG_W];
        buf_d[i].data = bus.req_data[i*XLEN +: XLEN];
      end else if (grant[i] || bus.flush) begin
        buf_v_d[i] = 1'b0;
      end
    end
  end

  // Output stage next state. The tag, data and source index keep their last
  // values when nothing is granted; only the valid bit drops.
  always_comb begin
    out_v_d   = any_grant;
    out_pkt_d = out_pkt_q;
    out_src_d = out_src_q;
    if (any_grant) begin
      out_pkt_d = buf_q[grant_idx];
      out_src_d = grant_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_v_q   <= '0;
      out_v_q   <= 1'b0;
      out_pkt_q <= '0;
      out_src_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      buf_v_q   <= buf_v_d;
      out_v_q   <= out_v_d;
      out_pkt_q <= out_pkt_d;
      out_src_q <= out_src_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  // The PRF data port, the status port and the CDB all carry the same
  // registered result.
  assign bus.prf_write_en       = out_v_q;
  assign bus.prf_write_addr     = out_pkt_q.tag;
  assign bus.prf_write_data     = out_pkt_q.data;
  assign bus.prf_status_wr_en   = out_v_q;
  assign bus.prf_status_wr_addr = out_pkt_q.tag;
  assign bus.cdb_valid          = out_v_q;
  assign bus.cdb_tag            = out_pkt_q.tag;
  assign bus.cdb_data           = out_pkt_q.data;
  assign bus.cdb_src            = out_src_q;

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_writeback_arbiter
// Self-checking bench for cdb_writeback_arbiter. It drives the FU request side
// of the interface and compares every PRF/CDB write against an expected queue.
// -----------------------------------------------------------------------------
module tb_cdb_writeback_arbiter;
  import cdb_writeback_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int SW = idx_width(NR);
  localparam int W  = SW + PREG_W + XLEN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cdb_writeback_arbiter_if #(.NUM_REQ(NR)) bus();

  cdb_writeback_arbiter #(.NUM_REQ(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  int             checks  = 0;
  int             errors  = 0;
  bit             ordered = 1'b1;
  logic [W-1:0]   exp_q[$];
  int             acc_q[$];
  int             wait_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] pk(input int src, input logic [PREG_W-1:0] tag,
                                      input logic [XLEN-1:0] data);
    return {SW'(src), tag, data};
  endfunction

  task automatic push_exp(input int src, input logic [PREG_W-1:0] tag, input logic [XLEN-1:0] data);
    exp_q.push_back(pk(src, tag, data));
    acc_q.push_back(cyc);
    wait_q.push_back(0);
  endtask

  // Output monitor: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] e;
    int           j;
    got = {bus.cdb_src, bus.prf_write_addr, bus.prf_write_data};
    if (bus.prf_write_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %0h expected no write (cycle %0d)", got, cyc);
      end else begin
        j = -1;
        if (ordered) begin
          j = 0;
          chk("write_order", got, exp_q[0]);
        end else begin
          for (int k = 0; k < exp_q.size(); k++) begin
            if (j < 0 && exp_q[k] == got) j = k;
          end
          if (j < 0) begin
            checks++;
            errors++;
            $display("FAIL lost_or_dup: got %0h expected one of %0d pending (cycle %0d)",
                     got, exp_q.size(), cyc);
          end else begin
            chk("fairness_wait", 64'(wait_q[j] <= NR - 1), 64'd1);
            for (int k = 0; k < exp_q.size(); k++) begin
              if (k != j && cyc >= acc_q[k] + 2) wait_q[k]++;
            end
          end
        end
        if (j >= 0) begin
          e = exp_q[j];
          chk("bus_mirror",
              {bus.prf_status_wr_en, bus.cdb_valid, bus.prf_status_wr_addr, bus.cdb_tag, bus.cdb_data},
              {2'b11, e[XLEN +: PREG_W], e[XLEN +: PREG_W], e[XLEN-1:0]});
          exp_q.delete(j);
          acc_q.delete(j);
          wait_q.delete(j);
        end
      end
    end else begin
      chk("idle_mirror", {bus.prf_status_wr_en, bus.cdb_valid}, 2'b00);
    end
  end

  // ---------------- driver tasks ----------------
  logic [NR-1:0]        acc;
  logic [NR*PREG_W-1:0] tg;
  logic [NR*XLEN-1:0]   dt;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Present one cycle of requests and report which ones were taken.
  task automatic drive_cycle(input logic [NR-1:0] vm, input logic [NR*PREG_W-1:0] t,
                             input logic [NR*XLEN-1:0] d, output logic [NR-1:0] a);
    bus.req_valid = vm;
    bus.req_tag   = t;
    bus.req_data  = d;
    @(negedge clk);
    a = vm & bus.req_ready;
    step();
    bus.req_valid = '0;
  endtask

  task automatic do_reset;
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.req_valid = '0;
    bus.req_tag   = '0;
    bus.req_data  = '0;
    @(negedge clk);
    chk("rst_ctl", {bus.prf_write_en, bus.prf_status_wr_en, bus.cdb_valid, bus.cdb_src}, 64'd0);
    chk("rst_addr", {bus.prf_write_addr, bus.prf_status_wr_addr, bus.cdb_tag}, 64'd0);
    chk("rst_data", {bus.prf_write_data, bus.cdb_data}, 64'd0);
    chk("rst_ready", bus.req_ready, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    wait_q.delete();
    step();
    chk("ready_after_rst", bus.req_ready, {NR{1'b1}});
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    chk("drain_pending", exp_q.size(), 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int                fu;
    logic [PREG_W-1:0] tag;
    logic [XLEN-1:0]   data;
    int                exp_src;
    logic [PREG_W-1:0] exp_tag;
    logic [XLEN-1:0]   exp_data;
  } vec_t;

  vec_t vecs[4];

  // Stress state
  logic [NR-1:0]      pv;
  logic [PREG_W-1:0]  pt [NR];
  logic [XLEN-1:0]    pd [NR];
  int                 seq;
  int                 a_cnt;
  logic [5:0]         exp_rdy0;

  initial begin
    vecs[0] = '{1, 6'd5,  32'hDEADBEEF, 1, 6'd5,  32'hDEADBEEF};
    vecs[1] = '{0, 6'd0,  32'h12345678, 0, 6'd0,  32'h12345678};
    vecs[2] = '{3, 6'd63, 32'hFFFFFFFF, 3, 6'd63, 32'hFFFFFFFF};
    vecs[3] = '{2, 6'd42, 32'hA5A55A5A, 2, 6'd42, 32'hA5A55A5A};

    do_reset();

    // --- single requests: 2-cycle latency, output holds afterwards ---
    for (int v = 0; v < 4; v++) begin
      tg = '0;
      dt = '0;
      tg[vecs[v].fu*PREG_W +: PREG_W] = vecs[v].tag;
      dt[vecs[v].fu*XLEN +: XLEN]     = vecs[v].data;
      drive_cycle(NR'(1) << vecs[v].fu, tg, dt, acc);
      chk("vec_accept", acc[vecs[v].fu], 64'd1);
      if (acc[vecs[v].fu]) push_exp(vecs[v].exp_src, vecs[v].exp_tag, vecs[v].exp_data);
      @(negedge clk);
      chk("vec_lat_c1", bus.prf_write_en, 64'd0);
      @(negedge clk);
      chk("vec_lat_c2", {bus.prf_write_en, bus.cdb_src}, {1'b1, SW'(vecs[v].exp_src)});
      @(negedge clk);
      chk("vec_idle_c3", bus.prf_write_en, 64'd0);
      chk("vec_hold", {bus.prf_write_addr, bus.prf_write_data}, {vecs[v].exp_tag, vecs[v].exp_data});
      step();
      wait_drain(10);
    end

    // --- all four FUs at once, pointer 0: tags 10..13 in cycles 2..5 ---
    do_reset();
    for (int i = 0; i < NR; i++) begin
      tg[i*PREG_W +: PREG_W] = PREG_W'(10 + i);
      dt[i*XLEN +: XLEN]     = 32'h1000_0000 + 32'(i);
    end
    drive_cycle({NR{1'b1}}, tg, dt, acc);
    chk("all4_accept", acc, {NR{1'b1}});
    for (int i = 0; i < NR; i++) push_exp(i, PREG_W'(10 + i), 32'h1000_0000 + 32'(i));
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      @(negedge clk);
      chk("all4_burst", {bus.prf_write_en, bus.prf_write_addr}, {1'b1, PREG_W'(10 + i)});
    end
    @(negedge clk);
    chk("all4_after", bus.prf_write_en, 64'd0);
    step();
    // Pointer should be back at 0, so FU0 beats FU1.
    tg = '0;
    dt = '0;
    tg[0 +: PREG_W] = 6'd7;       dt[0 +: XLEN]    = 32'h0000_0A00;
    tg[PREG_W +: PREG_W] = 6'd8;  dt[XLEN +: XLEN] = 32'h0000_0B00;
    drive_cycle(4'b0011, tg, dt, acc);
    chk("ptr_wrap_accept", acc, 64'h3);
    push_exp(0, 6'd7, 32'h0000_0A00);
    push_exp(1, 6'd8, 32'h0000_0B00);
    wait_drain(10);

    // --- FU0 streams while FU2 holds one result ---
    do_reset();
    exp_rdy0 = 6'b111011;   // bit c = expected req_ready[0] in cycle c
    a_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      bus.req_valid = {1'b0, (c == 0), 1'b0, 1'b1};
      bus.req_tag   = '0;
      bus.req_data  = '0;
      bus.req_tag[0 +: PREG_W]        = PREG_W'(20 + a_cnt);
      bus.req_data[0 +: XLEN]         = 32'hA000_0000 + 32'(a_cnt);
      bus.req_tag[2*PREG_W +: PREG_W] = 6'd40;
      bus.req_data[2*XLEN +: XLEN]    = 32'hB0B0_B0B0;
      @(negedge clk);
      chk("stream_ready0", bus.req_ready[0], exp_rdy0[c]);
      if (c == 3) chk("fu2_bcast", {bus.prf_write_en, bus.cdb_src}, {1'b1, SW'(2)});
      acc = bus.req_valid & bus.req_ready;
      if (acc[0]) begin
        push_exp(0, PREG_W'(20 + a_cnt), 32'hA000_0000 + 32'(a_cnt));
        a_cnt++;
      end
      if (acc[2]) push_exp(2, 6'd40, 32'hB0B0_B0B0);
      step();
    end
    bus.req_valid = '0;
    chk("stream_count", a_cnt, 64'd5);
    wait_drain(20);

    // --- flush with three buffered results and one in the output stage ---
    do_reset();
    for (int i = 0; i < NR; i++) begin
      tg[i*PREG_W +: PREG_W] = PREG_W'(20 + i);
      dt[i*XLEN +: XLEN]     = 32'hF000_0000 + 32'(i);
    end
    drive_cycle({NR{1'b1}}, tg, dt, acc);
    push_exp(0, 6'd20, 32'hF000_0000);   // already past arbitration when flush hits
    step();                              // cycle 2
    bus.flush     = 1'b1;
    bus.req_valid = 4'b0010;
    @(negedge clk);
    chk("flush_ready", bus.req_ready, 64'd0);
    chk("flush_c2_write", bus.prf_write_en, 64'd1);
    step();
    bus.flush     = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    chk("flush_next_idle", bus.prf_write_en, 64'd0);
    chk("flush_ready_back", bus.req_ready, {NR{1'b1}});
    step();
    repeat (5) step();
    tg = '0;
    dt = '0;
    tg[2*PREG_W +: PREG_W] = 6'd30;
    dt[2*XLEN +: XLEN]     = 32'hC0DE_0030;
    drive_cycle(4'b0100, tg, dt, acc);
    chk("post_flush_accept", acc, 64'h4);
    push_exp(2, 6'd30, 32'hC0DE_0030);
    wait_drain(10);

    // --- asynchronous reset in the middle of a burst ---
    do_reset();
    for (int i = 0; i < NR; i++) begin
      tg[i*PREG_W +: PREG_W] = PREG_W'(50 + i);
      dt[i*XLEN +: XLEN]     = 32'hE000_0000 + 32'(i);
    end
    drive_cycle({NR{1'b1}}, tg, dt, acc);
    push_exp(0, 6'd50, 32'hE000_0000);
    @(negedge clk);
    @(negedge clk);                     // FU0 on the bus in cycle 2
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ctl", {bus.prf_write_en, bus.prf_status_wr_en, bus.cdb_valid, bus.cdb_src}, 64'd0);
    chk("arst_data", {bus.prf_write_addr, bus.prf_write_data}, 64'd0);
    chk("arst_ready", bus.req_ready, 64'd0);
    chk("arst_pending", exp_q.size(), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("arst_ready_back", bus.req_ready, {NR{1'b1}});
    tg = '0;
    dt = '0;
    tg[0 +: PREG_W] = 6'd60;         dt[0 +: XLEN]      = 32'h6000_0000;
    tg[2*PREG_W +: PREG_W] = 6'd62;  dt[2*XLEN +: XLEN] = 32'h6200_0000;
    drive_cycle(4'b0101, tg, dt, acc);
    chk("arst_first_accept", acc, 64'h5);
    push_exp(0, 6'd60, 32'h6000_0000);
    push_exp(2, 6'd62, 32'h6200_0000);
    wait_drain(10);

    // --- random stress: exactly-once delivery and fairness bound ---
    do_reset();
    ordered = 1'b0;
    pv  = '0;
    seq = 1;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pv[i] && $urandom_range(0, 99) < 55) begin
          pv[i] = 1'b1;
          pt[i] = PREG_W'($urandom_range(0, (1 << PREG_W) - 1));
          pd[i] = XLEN'(seq);
          seq++;
        end
        bus.req_tag[i*PREG_W +: PREG_W] = pt[i];
        bus.req_data[i*XLEN +: XLEN]    = pd[i];
      end
      bus.req_valid = pv;
      @(negedge clk);
      acc = pv & bus.req_ready;
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) push_exp(i, pt[i], pd[i]);
      end
      step();
      pv = pv & ~acc;
    end
    bus.req_valid = '0;
    wait_drain(40);
    ordered = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case something stalls.
  initial begin
    #1000000;
    errors++;
    $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
